// File: rtl/sdr_adapter_pkg.sv
// Shared helpers and types for the SDRAM data-width adapter.
package sdr_adapter_pkg;

  typedef enum logic {IDLE, SEND} wr_state_t;

  function automatic int unsigned ratio_f(input int unsigned app_dw, input int unsigned sdr_dw);
    return app_dw / sdr_dw;
  endfunction

  // Counter width that stays at least one bit when only one value is needed.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit sdr_dw_legal(input int unsigned dw);
    return (dw == 8) || (dw == 16) || (dw == 32);
  endfunction

endpackage

// File: rtl/sdr_width_adapter_if.sv
// Application and SDRAM-side handshake signals of the width adapter.
interface sdr_width_adapter_if #(
  parameter int unsigned APP_DW = 32,
  parameter int unsigned SDR_DW = 8
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [APP_DW-1:0]     wr_data;
  logic [APP_DW/8-1:0]   wr_be;
  logic                  sdr_wr_valid;
  logic                  sdr_wr_ready;
  logic [SDR_DW-1:0]     sdr_wr_data;
  logic [SDR_DW/8-1:0]   sdr_wr_dqm;
  logic                  sdr_rd_valid;
  logic [SDR_DW-1:0]     sdr_rd_data;
  logic                  rd_flush;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [APP_DW-1:0]     rd_data;
  logic                  rd_overflow;

  modport slave (
    input  wr_valid, wr_data, wr_be, sdr_wr_ready, sdr_rd_valid, sdr_rd_data,
           rd_flush, rd_ready,
    output wr_ready, sdr_wr_valid, sdr_wr_data, sdr_wr_dqm, rd_valid, rd_data,
           rd_overflow
  );

  modport master (
    output wr_valid, wr_data, wr_be, sdr_wr_ready, sdr_rd_valid, sdr_rd_data,
           rd_flush, rd_ready,
    input  wr_ready, sdr_wr_valid, sdr_wr_data, sdr_wr_dqm, rd_valid, rd_data,
           rd_overflow
  );
endinterface

// File: rtl/sdr_rd_fifo.sv
// Circular read-word FIFO with wrap-bit pointers, flush and sticky overflow.
module sdr_rd_fifo
  import sdr_adapter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             empty_c,
  output logic [WIDTH-1:0] head_data_c,
  output logic             overflow
);
  localparam int unsigned AW = cnt_w(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic             full_c;
  logic             do_push;
  logic             do_pop;

  assign empty_c     = (wptr_q == rptr_q);
  assign full_c      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop      = pop && !empty_c;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push     = push && (!full_c || do_pop);
  assign head_data_c = empty_c ? '0 : mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sdr_width_adapter.sv
// App-word <-> SDRAM-beat width adapter: write serialiser with DQM, read assembler plus FIFO.
module sdr_width_adapter
  import sdr_adapter_pkg::*;
#(
  parameter int unsigned APP_DW   = 32,
  parameter int unsigned SDR_DW   = 8,
  parameter int unsigned RD_DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  sdr_width_adapter_if.slave bus
);
  localparam int unsigned RATIO  = ratio_f(APP_DW, SDR_DW);
  localparam int unsigned BEAT_W = cnt_w(RATIO);
  localparam int unsigned BE_W   = APP_DW / 8;
  localparam int unsigned DQM_W  = SDR_DW / 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);
  localparam bit SDR_DW_LEGAL = sdr_dw_legal(SDR_DW);

  if (!SDR_DW_LEGAL || (APP_DW % SDR_DW) != 0 || RD_DEPTH < 2 ||
      (RD_DEPTH & (RD_DEPTH - 1)) != 0) begin : g_param_err
    $error("sdr_width_adapter: illegal APP_DW/SDR_DW/RD_DEPTH combination");
  end

  // ---------------- write path ----------------
  wr_state_t          state_q, state_d;
  logic [BEAT_W-1:0]  wr_beat_q, wr_beat_d;
  logic [APP_DW-1:0]  word_q, word_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic               valid_q, valid_d;
  logic [SDR_DW-1:0]  data_q, data_d;
  logic [DQM_W-1:0]   dqm_q, dqm_d;
  logic               last_beat_c;
  logic               wr_ready_c;

  always_comb begin
    state_d     = state_q;
    wr_beat_d   = wr_beat_q;
    word_d      = word_q;
    be_d        = be_q;
    valid_d     = valid_q;
    data_d      = data_q;
    dqm_d       = dqm_q;
    last_beat_c = (state_q == SEND) && (wr_beat_q == LAST_BEAT);
    wr_ready_c  = (state_q == IDLE) || (last_beat_c && bus.sdr_wr_ready);

    if (wr_ready_c && bus.wr_valid) begin
      // New word: beat 0 goes out straight from the incoming word.
      state_d   = SEND;
      wr_beat_d = '0;
      word_d    = bus.wr_data;
      be_d      = bus.wr_be;
      valid_d   = 1'b1;
      data_d    = bus.wr_data[SDR_DW-1:0];
      dqm_d     = ~bus.wr_be[DQM_W-1:0];
    end else if (state_q == SEND && bus.sdr_wr_ready) begin
      if (last_beat_c) begin
        state_d   = IDLE;
        wr_beat_d = '0;
        valid_d   = 1'b0;
        data_d    = '0;
        dqm_d     = '1;
      end else begin
        wr_beat_d = wr_beat_q + 1'b1;
        data_d    = word_q[int'(wr_beat_d)*SDR_DW +: SDR_DW];
        dqm_d     = ~be_q[int'(wr_beat_d)*DQM_W +: DQM_W];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      wr_beat_q <= '0;
      word_q    <= '0;
      be_q      <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      dqm_q     <= '1;
    end else begin
      state_q   <= state_d;
      wr_beat_q <= wr_beat_d;
      word_q    <= word_d;
      be_q      <= be_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      dqm_q     <= dqm_d;
    end
  end

  assign bus.wr_ready     = wr_ready_c;
  assign bus.sdr_wr_valid = valid_q;
  assign bus.sdr_wr_data  = data_q;
  assign bus.sdr_wr_dqm   = dqm_q;

  // ---------------- read path ----------------
  logic [BEAT_W-1:0] rd_beat_q;
  logic [APP_DW-1:0] asm_q;
  logic [APP_DW-1:0] asm_c;
  logic              beat_ok_c;
  logic              push_c;
  logic              empty_c;

  // A beat arriving together with a flush is discarded.
  always_comb begin
    beat_ok_c = bus.sdr_rd_valid && !bus.rd_flush;
    asm_c     = asm_q;
    asm_c[int'(rd_beat_q)*SDR_DW +: SDR_DW] = bus.sdr_rd_data;
    push_c    = beat_ok_c && (rd_beat_q == LAST_BEAT);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || bus.rd_flush) begin
      rd_beat_q <= '0;
      asm_q     <= '0;
    end else if (beat_ok_c) begin
      asm_q     <= asm_c;
      rd_beat_q <= (rd_beat_q == LAST_BEAT) ? '0 : rd_beat_q + 1'b1;
    end
  end

  sdr_rd_fifo #(
    .WIDTH (APP_DW),
    .DEPTH (RD_DEPTH)
  ) u_rd_fifo (
    .clk         (sys_clk),
    .rst         (sys_rst),
    .push        (push_c),
    .push_data   (asm_c),
    .pop         (bus.rd_ready),
    .flush       (bus.rd_flush),
    .empty_c     (empty_c),
    .head_data_c (bus.rd_data),
    .overflow    (bus.rd_overflow)
  );

  assign bus.rd_valid = !empty_c;

endmodule
